// File: rtl/tlul_pkg.sv
// TL-UL bus widths, opcodes, channel payloads and the response slot entry
// shared by the ordered host adapter.
package tlul_pkg;

  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_DBW = TL_DW / 8;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_SZW = 2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tlul_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tlul_d2h_t;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             err;
    logic [TL_DW-1:0] data;
  } tlul_rsp_slot_t;

endpackage

// File: rtl/tlul_rsp_reorder.sv
// Per-source response slot table: captures D beats out of order and
// retires them to the host strictly in issue order.
module tlul_rsp_reorder
  import tlul_pkg::*;
#(
  parameter  int unsigned MAX_REQS = 4,
  localparam int unsigned SlotW    = (MAX_REQS > 1) ? $clog2(MAX_REQS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_i,
  input  logic [SlotW-1:0]  iss_slot_i,
  input  logic              d_valid_i,
  input  logic [TL_AIW-1:0] d_source_i,
  input  logic [TL_DW-1:0]  d_data_i,
  input  logic              d_error_i,
  output logic              retire_c,
  output logic              valid_o,
  output logic [TL_DW-1:0]  rdata_o,
  output logic              err_o,
  output logic              unexp_o
);

  tlul_rsp_slot_t slot_q [MAX_REQS];
  tlul_rsp_slot_t slot_d [MAX_REQS];
  logic [SlotW-1:0] ret_q, ret_d;
  logic             valid_q, valid_d;
  logic [TL_DW-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             unexp_q, unexp_d;

  logic             src_ok_c;
  logic             accept_c;
  logic [SlotW-1:0] d_idx_c;

  always_comb begin
    slot_d   = slot_q;
    ret_d    = ret_q;
    valid_d  = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unexp_d  = 1'b0;
    src_ok_c = ({1'b0, d_source_i} < (TL_AIW+1)'(MAX_REQS));
    d_idx_c  = SlotW'(d_source_i);
    // Slot lookup is only trusted once the source is known to be in range.
    accept_c = d_valid_i & src_ok_c & slot_q[d_idx_c].busy & ~slot_q[d_idx_c].done;
    retire_c = slot_q[ret_q].done;

    if (retire_c) begin
      valid_d                = 1'b1;
      rdata_d                = slot_q[ret_q].data;
      err_d                  = slot_q[ret_q].err;
      slot_d[ret_q].busy     = 1'b0;
      slot_d[ret_q].done     = 1'b0;
      ret_d                  = (ret_q == SlotW'(MAX_REQS - 1)) ? '0 : ret_q + SlotW'(1);
    end

    if (accept_c) begin
      slot_d[d_idx_c].data = d_data_i;
      slot_d[d_idx_c].err  = d_error_i;
      slot_d[d_idx_c].done = 1'b1;
    end

    unexp_d = d_valid_i & ~accept_c;

    if (issue_i) begin
      slot_d[iss_slot_i].busy = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MAX_REQS); i++) begin
        slot_q[i] <= '0;
      end
      ret_q   <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      unexp_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      ret_q   <= ret_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      unexp_q <= unexp_d;
    end
  end

  assign valid_o = valid_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;
  assign unexp_o = unexp_q;

endmodule

// File: rtl/tlul_host_adapter_ordered.sv
// Host req/gnt/valid to TL-UL bridge with up to MAX_REQS outstanding
// transactions and in-order response delivery.
module tlul_host_adapter_ordered
  import tlul_pkg::*;
#(
  parameter  int unsigned MAX_REQS = 4,
  localparam int unsigned SlotW    = (MAX_REQS > 1) ? $clog2(MAX_REQS) : 1,
  localparam int unsigned CntW     = $clog2(MAX_REQS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [TL_AW-1:0]  addr_i,
  input  logic              we_i,
  input  logic [TL_DW-1:0]  wdata_i,
  input  logic [TL_DBW-1:0] be_i,
  output logic              valid_o,
  output logic [TL_DW-1:0]  rdata_o,
  output logic              err_o,
  output logic [CntW-1:0]   outstanding_o,
  output logic              unexp_o,
  output tlul_h2d_t         tl_h_c_a,
  input  tlul_d2h_t         tl_h_c_d
);

  localparam int unsigned AddrLsb = $clog2(TL_DBW);

  if ((MAX_REQS < 1) || (MAX_REQS > (2 ** TL_AIW))) begin : g_bad_max_reqs
    $error("MAX_REQS must lie in 1..2**TL_AIW");
  end

  logic [SlotW-1:0] iss_q, iss_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full_c;
  logic             issue_c;
  logic             retire_c;
  logic             unused_c;

  assign full_c  = (cnt_q == CntW'(MAX_REQS));
  // Full blocks issue even when a retire frees a slot in the same cycle.
  assign gnt_o   = tl_h_c_d.a_ready & ~full_c;
  assign issue_c = req_i & gnt_o;

  always_comb begin
    tl_h_c_a           = '0;
    tl_h_c_a.a_valid   = req_i & ~full_c;
    tl_h_c_a.a_opcode  = Get;
    tl_h_c_a.a_param   = 3'b000;
    tl_h_c_a.a_size    = TL_SZW'(AddrLsb);
    tl_h_c_a.a_source  = TL_AIW'(iss_q);
    tl_h_c_a.a_address = {addr_i[TL_AW-1:AddrLsb], {AddrLsb{1'b0}}};
    tl_h_c_a.a_mask    = {TL_DBW{1'b1}};
    tl_h_c_a.a_data    = wdata_i;
    tl_h_c_a.d_ready   = 1'b1;
    if (we_i) begin
      tl_h_c_a.a_opcode = (&be_i) ? PutFullData : PutPartialData;
      tl_h_c_a.a_mask   = be_i;
    end
  end

  always_comb begin
    iss_d = iss_q;
    cnt_d = cnt_q;
    if (issue_c) begin
      iss_d = (iss_q == SlotW'(MAX_REQS - 1)) ? '0 : iss_q + SlotW'(1);
    end
    case ({issue_c, retire_c})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      iss_q <= '0;
      cnt_q <= '0;
    end else begin
      iss_q <= iss_d;
      cnt_q <= cnt_d;
    end
  end

  assign outstanding_o = cnt_q;

  tlul_rsp_reorder #(
    .MAX_REQS (MAX_REQS)
  ) u_reorder (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .issue_i    (issue_c),
    .iss_slot_i (iss_q),
    .d_valid_i  (tl_h_c_d.d_valid),
    .d_source_i (tl_h_c_d.d_source),
    .d_data_i   (tl_h_c_d.d_data),
    .d_error_i  (tl_h_c_d.d_error),
    .retire_c   (retire_c),
    .valid_o    (valid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .unexp_o    (unexp_o)
  );

  // D-channel fields and address low bits carry no meaning for this host.
  assign unused_c = ^{tl_h_c_d.d_opcode, tl_h_c_d.d_param, tl_h_c_d.d_size,
                      tl_h_c_d.d_sink, addr_i[AddrLsb-1:0]};

endmodule
